// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled SCK/CS/MOSI, MSB-first receive with valid/overrun, buffered transmit.
// Optional D/C capture is enabled by defining SPI_TARGET_DC_EN.
module spi_target #(
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  output logic       spi_miso,
  input  logic [7:0] tx_data,
  input  logic       tx_write,
  output logic       tx_full,
  output logic [7:0] rx_data,
  output logic       rx_dc,
  output logic       rx_valid,
  input  logic       rx_read,
  output logic       rx_overrun,
  input  logic       clear_status,
  output logic       busy
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sck_p0, r_sck_p1, r_sck_p2;
  logic        r_cs_p0, r_cs_p1, r_cs_p2;
  logic        r_mosi_p0, r_mosi_p1;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_tx_shift;
  logic [7:0]  r_tx_buf;
  logic        r_tx_full;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_rx_overrun;

  logic        w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
  logic        w_bit_rise, w_bit_fall, w_start, w_load, w_byte_done;
  logic [7:0]  w_rx_byte;

  // Stage p0/p1: two-flop synchronizers; p2: previous level for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck_p0 <= 1'b0;
      r_sck_p1 <= 1'b0;
      r_sck_p2 <= 1'b0;
      r_cs_p0  <= 1'b1;
      r_cs_p1  <= 1'b1;
      r_cs_p2  <= 1'b1;
    end else begin
      r_sck_p0 <= spi_sck;
      r_sck_p1 <= r_sck_p0;
      r_sck_p2 <= r_sck_p1;
      r_cs_p0  <= spi_cs_n;
      r_cs_p1  <= r_cs_p0;
      r_cs_p2  <= r_cs_p1;
    end
  end

  always_ff @(posedge clk) begin
    r_mosi_p0 <= spi_mosi;
    r_mosi_p1 <= r_mosi_p0;
  end

  assign w_sck_rise = r_sck_p1 & ~r_sck_p2;
  assign w_sck_fall = ~r_sck_p1 & r_sck_p2;
  assign w_cs_fall  = ~r_cs_p1 & r_cs_p2;
  assign w_cs_rise  = r_cs_p1 & ~r_cs_p2;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_bit_rise  = 1'b0;
    w_bit_fall  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = S_ACTIVE;
          w_start     = 1'b1;
        end
      end
      S_ACTIVE: begin
        // A CS rise takes priority over any coincident SCK edge
        if (w_cs_rise) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_bit_rise = w_sck_rise;
          w_bit_fall = w_sck_fall;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_load      = w_start | (w_bit_fall & (r_bit_cnt == 3'd0));
  assign w_byte_done = w_bit_rise & (r_bit_cnt == 3'd7);
  assign w_rx_byte   = {r_rx_shift[6:0], r_mosi_p1};

  // Stage p3: bit counter, buffer status and receive status
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt    <= 3'd0;
      r_tx_full    <= 1'b0;
      r_rx_data    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      if (w_start)         r_bit_cnt <= 3'd0;
      else if (w_bit_rise) r_bit_cnt <= r_bit_cnt + 3'd1;

      // A write on the load cycle refills the buffer after the old byte leaves
      if (tx_write)    r_tx_full <= 1'b1;
      else if (w_load) r_tx_full <= 1'b0;

      if (w_byte_done) begin
        r_rx_data  <= w_rx_byte;
        r_rx_valid <= 1'b1;
      end else if (rx_read) begin
        r_rx_valid <= 1'b0;
      end

      if (w_byte_done && r_rx_valid && !rx_read) r_rx_overrun <= 1'b1;
      else if (clear_status)                     r_rx_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_write) r_tx_buf <= tx_data;
    if (w_bit_rise) r_rx_shift <= w_rx_byte;
    if (w_load)          r_tx_shift <= r_tx_full ? r_tx_buf : IDLE_BYTE;
    else if (w_bit_fall) r_tx_shift <= {r_tx_shift[6:0], 1'b0};
  end

`ifdef SPI_TARGET_DC_EN
  logic r_dc_p0, r_dc_p1;
  logic r_rx_dc;

  always_ff @(posedge clk) begin
    r_dc_p0 <= spi_dc;
    r_dc_p1 <= r_dc_p0;
  end

  always_ff @(posedge clk) begin
    if (rst)              r_rx_dc <= 1'b0;
    else if (w_byte_done) r_rx_dc <= r_dc_p1;
  end

  assign rx_dc = r_rx_dc;
`else
  logic w_unused_dc;
  assign w_unused_dc = spi_dc;
  assign rx_dc       = 1'b0;
`endif

  assign spi_miso   = (r_state == S_ACTIVE) ? r_tx_shift[7] : 1'b1;
  assign tx_full    = r_tx_full;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign rx_overrun = r_rx_overrun;
  assign busy       = (r_state == S_ACTIVE);

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a bit-banged SPI controller at clk/8 with rx/tx scoreboards.
module tb_spi_target;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_sck, spi_cs_n, spi_mosi, spi_dc;
  logic       spi_miso;
  logic [7:0] tx_data;
  logic       tx_write, tx_full;
  logic [7:0] rx_data;
  logic       rx_dc, rx_valid, rx_read, rx_overrun, clear_status, busy;

  int total = 0;
  int bad   = 0;

  logic [8:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] mi;

`ifdef SPI_TARGET_DC_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  spi_target #(.IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .rst(rst),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_dc(spi_dc),
    .spi_miso(spi_miso),
    .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full),
    .rx_data(rx_data), .rx_dc(rx_dc), .rx_valid(rx_valid), .rx_read(rx_read),
    .rx_overrun(rx_overrun), .clear_status(clear_status), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_fall(input bit wr_on_load, input logic [7:0] wdata);
    spi_cs_n = 1'b0;
    if (wr_on_load) begin
      tick(2);
      tx_data  = wdata;
      tx_write = 1'b1;
      tick(1);
      tx_write = 1'b0;
      tick(3);
    end else begin
      tick(6);
    end
  endtask

  task automatic cs_rise();
    tick(4);
    spi_cs_n = 1'b1;
    tick(6);
  endtask

  task automatic pulse_write(input logic [7:0] d);
    tx_data  = d;
    tx_write = 1'b1;
    tick(1);
    tx_write = 1'b0;
  endtask

  task automatic pulse_read();
    rx_read = 1'b1;
    tick(1);
    rx_read = 1'b0;
  endtask

  // Mode 0: MOSI changes with SCK low, both sides sample on the SCK rise
  task automatic spi_xfer(input logic [7:0] mo, input bit dc, input int nbits,
                          input bit read_last, output logic [7:0] mi_o);
    mi_o = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = mo[i];
      spi_dc   = dc;
      tick(4);
      mi_o[i] = spi_miso;
      spi_sck = 1'b1;
      if (read_last && i == 0) begin
        tick(2);
        rx_read = 1'b1;
        tick(1);
        rx_read = 1'b0;
        tick(1);
      end else begin
        tick(4);
      end
      spi_sck = 1'b0;
    end
  endtask

  task automatic expect_rx(input string tag, input bit do_read);
    logic [8:0] e;
    int n;
    n = 0;
    while (!rx_valid && n < 20) begin
      tick(1);
      n++;
    end
    check({tag, "_valid"}, 32'(rx_valid), 32'd1);
    if (rx_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_queue: observed=empty expected=entry", tag);
    end else begin
      e = rx_q.pop_front();
      check({tag, "_data"}, 32'(rx_data), 32'(e[7:0]));
      check({tag, "_dc"}, 32'(rx_dc), 32'(e[8]));
    end
    if (do_read) begin
      pulse_read();
      check({tag, "_read"}, 32'(rx_valid), 32'd0);
    end
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] got);
    logic [7:0] e;
    if (tx_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_queue: observed=empty expected=entry", tag);
    end else begin
      e = tx_q.pop_front();
      check(tag, 32'(got), 32'(e));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; spi_dc = 1'b0;
    tx_data = 8'h00; tx_write = 1'b0; rx_read = 1'b0; clear_status = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(1);
    check("rst_miso", 32'(spi_miso), 32'd1);
    check("rst_tx_full", 32'(tx_full), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_dc", 32'(rx_dc), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_overrun", 32'(rx_overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Byte receive with dc=1, nothing queued for transmit
    cs_fall(1'b0, 8'h00);
    check("rx_busy", 32'(busy), 32'd1);
    rx_q.push_back({DC_EN, 8'hA5});
    tx_q.push_back(8'hFF);
    spi_xfer(8'hA5, 1'b1, 8, 1'b0, mi);
    expect_tx("rx_miso", mi);
    expect_rx("rx_a5", 1'b1);
    cs_rise();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_miso", 32'(spi_miso), 32'd1);

    // Byte transmit, then idle byte
    pulse_write(8'h3C);
    check("tx_full_set", 32'(tx_full), 32'd1);
    cs_fall(1'b0, 8'h00);
    check("tx_full_clr", 32'(tx_full), 32'd0);
    tx_q.push_back(8'h3C); tx_q.push_back(8'hFF);
    rx_q.push_back({1'b0, 8'h00}); rx_q.push_back({1'b0, 8'h0F});
    spi_xfer(8'h00, 1'b0, 8, 1'b0, mi);
    expect_tx("tx_3c", mi);
    expect_rx("tx_b1", 1'b1);
    spi_xfer(8'h0F, 1'b0, 8, 1'b0, mi);
    expect_tx("tx_ff", mi);
    expect_rx("tx_b2", 1'b1);
    cs_rise();

    // Overrun, clear, then a read on the completion cycle
    cs_fall(1'b0, 8'h00);
    spi_xfer(8'h11, 1'b0, 8, 1'b0, mi);
    spi_xfer(8'h22, 1'b0, 8, 1'b0, mi);
    check("ovr_data", 32'(rx_data), 32'h22);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_flag", 32'(rx_overrun), 32'd1);
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    check("ovr_clear", 32'(rx_overrun), 32'd0);
    pulse_read();
    spi_xfer(8'h33, 1'b0, 8, 1'b0, mi);
    check("rdc_first", 32'(rx_valid), 32'd1);
    spi_xfer(8'h44, 1'b0, 8, 1'b1, mi);
    tick(1);
    check("rdc_data", 32'(rx_data), 32'h44);
    check("rdc_valid", 32'(rx_valid), 32'd1);
    check("rdc_no_ovr", 32'(rx_overrun), 32'd0);
    pulse_read();
    check("rdc_read", 32'(rx_valid), 32'd0);
    cs_rise();

    // Abort after 5 bits, then a full byte
    cs_fall(1'b0, 8'h00);
    spi_xfer(8'hE7, 1'b0, 5, 1'b0, mi);
    cs_rise();
    check("abort_none", 32'(rx_valid), 32'd0);
    cs_fall(1'b0, 8'h00);
    rx_q.push_back({1'b0, 8'h81});
    spi_xfer(8'h81, 1'b0, 8, 1'b0, mi);
    expect_rx("abort_81", 1'b1);
    check("abort_no_ovr", 32'(rx_overrun), 32'd0);
    cs_rise();

    // Back-to-back: write during byte 1 goes out as byte 2
    cs_fall(1'b0, 8'h00);
    pulse_write(8'hC3);
    tx_q.push_back(8'hFF); tx_q.push_back(8'hC3);
    rx_q.push_back({1'b0, 8'h12}); rx_q.push_back({1'b0, 8'h34});
    spi_xfer(8'h12, 1'b0, 8, 1'b0, mi);
    expect_tx("b2b_b1", mi);
    expect_rx("b2b_r1", 1'b1);
    spi_xfer(8'h34, 1'b0, 8, 1'b0, mi);
    expect_tx("b2b_c3", mi);
    expect_rx("b2b_r2", 1'b1);
    check("b2b_empty", 32'(tx_full), 32'd0);
    cs_rise();

    // Write coinciding with the CS-fall load
    pulse_write(8'h5A);
    cs_fall(1'b1, 8'h96);
    check("coin_full", 32'(tx_full), 32'd1);
    tx_q.push_back(8'h5A); tx_q.push_back(8'h96);
    rx_q.push_back({1'b0, 8'h56}); rx_q.push_back({1'b0, 8'h78});
    spi_xfer(8'h56, 1'b0, 8, 1'b0, mi);
    expect_tx("coin_old", mi);
    expect_rx("coin_r1", 1'b1);
    spi_xfer(8'h78, 1'b0, 8, 1'b0, mi);
    expect_tx("coin_new", mi);
    expect_rx("coin_r2", 1'b1);
    check("coin_empty", 32'(tx_full), 32'd0);
    cs_rise();

    // Reset mid-byte with status set
    cs_fall(1'b0, 8'h00);
    pulse_write(8'h77);
    spi_xfer(8'hEE, 1'b0, 8, 1'b0, mi);
    spi_xfer(8'hB4, 1'b0, 4, 1'b0, mi);
    rst = 1'b1;
    tick(2);
    check("mid_rst_miso", 32'(spi_miso), 32'd1);
    check("mid_rst_tx_full", 32'(tx_full), 32'd0);
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_ovr", 32'(rx_overrun), 32'd0);
    check("mid_rst_data", 32'(rx_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    spi_cs_n = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    cs_fall(1'b0, 8'h00);
    rx_q.push_back({DC_EN, 8'h5E});
    tx_q.push_back(8'hFF);
    spi_xfer(8'h5E, 1'b1, 8, 1'b0, mi);
    expect_tx("post_rst_miso", mi);
    expect_rx("post_rst_5e", 1'b1);
    cs_rise();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
